// File: rtl/branch_ctrl_pkg.sv
// Shared branch encodings, FSM state type and decode helpers for the branch
// resolution logic in ID.
package branch_ctrl_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STALL = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  function automatic logic op_is_branch(input logic [5:0] op, input logic [4:0] rt);
    logic res;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: res = 1'b1;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: res = 1'b1;
          default:                                res = 1'b0;
        endcase
      end
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_link(input logic [5:0] op, input logic [4:0] rt);
    return (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
  endfunction

  // Only the two-register compares read rt; REGIMM reuses the rt field as a sub-opcode.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_ctrl_hazard.sv
// Combinational operand hazard check for a branch in ID: required stall
// count and MEM-stage forward selects.
module branch_hazard_detect
  import branch_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [5:0] id_op_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_wa_i,
  input  logic       ex_load_i,
  input  logic       mem_wreg_i,
  input  logic [4:0] mem_wa_i,
  input  logic       mem_load_i,
  output logic       is_branch_o,
  output logic       is_link_o,
  output logic [1:0] stall_n_o,
  output logic       fwd_a_o,
  output logic       fwd_b_o
);

  logic       use_a_s, use_b_s;
  logic       ex_a_s, ex_b_s, mem_a_s, mem_b_s;
  logic [1:0] n_a_s, n_b_s;

  // Register 0 is hardwired, so a match on it is never a dependency.
  always_comb begin
    is_branch_o = id_valid_i && op_is_branch(id_op_i, id_rt_i);
    is_link_o   = id_valid_i && op_is_link(id_op_i, id_rt_i);
    use_a_s     = is_branch_o && (id_rs_i != 5'd0);
    use_b_s     = is_branch_o && op_uses_rt(id_op_i) && (id_rt_i != 5'd0);

    ex_a_s  = use_a_s && ex_wreg_i  && (ex_wa_i  == id_rs_i);
    ex_b_s  = use_b_s && ex_wreg_i  && (ex_wa_i  == id_rt_i);
    mem_a_s = use_a_s && mem_wreg_i && (mem_wa_i == id_rs_i);
    mem_b_s = use_b_s && mem_wreg_i && (mem_wa_i == id_rt_i);

    if (ex_a_s) begin
      n_a_s = ex_load_i ? 2'd2 : 2'd1;
    end else if (mem_a_s && mem_load_i) begin
      n_a_s = 2'd1;
    end else begin
      n_a_s = 2'd0;
    end

    if (ex_b_s) begin
      n_b_s = ex_load_i ? 2'd2 : 2'd1;
    end else if (mem_b_s && mem_load_i) begin
      n_b_s = 2'd1;
    end else begin
      n_b_s = 2'd0;
    end

    stall_n_o = (n_a_s > n_b_s) ? n_a_s : n_b_s;
    // A younger EX writer shadows the MEM value; that case stalls instead.
    fwd_a_o   = mem_a_s && !mem_load_i && !ex_a_s;
    fwd_b_o   = mem_b_s && !mem_load_i && !ex_b_s;
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: resolves branches, stalls on unresolved
// operands and holds a resolved redirect across downstream freezes.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_wreg,
  input  logic [4:0] ex_wa,
  input  logic       ex_load,
  input  logic       mem_wreg,
  input  logic [4:0] mem_wa,
  input  logic       mem_load,
  input  logic       ext_stall,
  input  logic       cmp_y,
  output logic       stall_id,
  output logic       fwd_a,
  output logic       fwd_b,
  output logic       pc_src,
  output logic       link_we
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       taken_q, taken_d;

  logic       is_branch_s, is_link_s, fwd_a_s, fwd_b_s;
  logic [1:0] stall_n_s;
  logic       stall_s, pc_src_s;

  branch_hazard_detect u_hazard (
    .id_valid_i  (id_valid),
    .id_op_i     (id_op),
    .id_rs_i     (id_rs),
    .id_rt_i     (id_rt),
    .ex_wreg_i   (ex_wreg),
    .ex_wa_i     (ex_wa),
    .ex_load_i   (ex_load),
    .mem_wreg_i  (mem_wreg),
    .mem_wa_i    (mem_wa),
    .mem_load_i  (mem_load),
    .is_branch_o (is_branch_s),
    .is_link_o   (is_link_s),
    .stall_n_o   (stall_n_s),
    .fwd_a_o     (fwd_a_s),
    .fwd_b_o     (fwd_b_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    taken_d  = taken_q;
    stall_s  = 1'b0;
    pc_src_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_branch_s) begin
          if (stall_n_s != 2'd0) begin
            stall_s = 1'b1;
            cnt_d   = stall_n_s;
            state_d = ST_STALL;
          end else if (ext_stall) begin
            pc_src_s = cmp_y;
            taken_d  = cmp_y;
            state_d  = ST_HOLD;
          end else begin
            pc_src_s = cmp_y;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        stall_s = 1'b1;
        if (!id_valid) begin
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (!ext_stall) begin
          // Saturating countdown: the last step lands on 0 and re-evaluates.
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HOLD: begin
        pc_src_s = taken_q;
        if (!ext_stall) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
        taken_d = 1'b0;
      end
    endcase
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    stall_id = !rst && stall_s;
    pc_src   = !rst && pc_src_s;
    fwd_a    = !rst && fwd_a_s;
    fwd_b    = !rst && fwd_b_s;
    link_we  = !rst && is_link_s && !stall_s;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios followed by random
// traffic, all compared against a countdown/flag reference model.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt;
  logic       ex_wreg, ex_load, mem_wreg, mem_load;
  logic [4:0] ex_wa, mem_wa;
  logic       ext_stall, cmp_y;
  logic       stall_id, fwd_a, fwd_b, pc_src, link_we;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state: remaining stall cycles, pending held redirect
  int m_stall_left = 0;
  bit m_hold       = 1'b0;
  bit m_taken      = 1'b0;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_wreg(ex_wreg), .ex_wa(ex_wa), .ex_load(ex_load),
    .mem_wreg(mem_wreg), .mem_wa(mem_wa), .mem_load(mem_load),
    .ext_stall(ext_stall), .cmp_y(cmp_y),
    .stall_id(stall_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_src(pc_src), .link_we(link_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_is_branch();
    if (!id_valid) return 1'b0;
    if (id_op inside {6'd4, 6'd5, 6'd6, 6'd7}) return 1'b1;
    return (id_op == 6'd1) && (id_rt inside {5'd0, 5'd1, 5'd16, 5'd17});
  endfunction

  function automatic int m_need(input bit used, input logic [4:0] r);
    if (!used || r == 5'd0) return 0;
    if (ex_wreg && ex_wa == r) return ex_load ? 2 : 1;
    if (mem_wreg && mem_wa == r && mem_load) return 1;
    return 0;
  endfunction

  function automatic bit m_fwd(input bit used, input logic [4:0] r);
    if (!used || r == 5'd0) return 1'b0;
    if (ex_wreg && ex_wa == r) return 1'b0;
    return mem_wreg && (mem_wa == r) && !mem_load;
  endfunction

  // Compare outputs against the model, then advance the model over the coming edge.
  task automatic model_check();
    bit e_stall, e_pc, e_fa, e_fb, e_link, br, use_b;
    int need;
    e_stall = 1'b0; e_pc = 1'b0; e_fa = 1'b0; e_fb = 1'b0; e_link = 1'b0;
    if (rst) begin
      m_stall_left = 0; m_hold = 1'b0; m_taken = 1'b0;
    end else begin
      br    = m_is_branch();
      use_b = br && (id_op == 6'd4 || id_op == 6'd5);
      e_fa  = m_fwd(br, id_rs);
      e_fb  = m_fwd(use_b, id_rt);
      if (m_stall_left > 0) begin
        e_stall = 1'b1;
        if (!id_valid) m_stall_left = 0;
        else if (!ext_stall) m_stall_left--;
      end else if (m_hold) begin
        e_pc = m_taken;
        if (!ext_stall) m_hold = 1'b0;
      end else if (br) begin
        need = m_need(1'b1, id_rs);
        if (m_need(use_b, id_rt) > need) need = m_need(use_b, id_rt);
        if (need > 0) begin
          e_stall = 1'b1;
          m_stall_left = need;
        end else begin
          e_pc = cmp_y;
          if (ext_stall) begin
            m_hold = 1'b1; m_taken = cmp_y;
          end
        end
      end
      e_link = id_valid && id_op == 6'd1 && (id_rt == 5'd16 || id_rt == 5'd17) && !e_stall;
    end
    check("stall_id", stall_id, e_stall);
    check("pc_src",   pc_src,   e_pc);
    check("fwd_a",    fwd_a,    e_fa);
    check("fwd_b",    fwd_b,    e_fb);
    check("link_we",  link_we,  e_link);
  endtask

  task automatic apply(input bit r, input bit v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input bit exw, input logic [4:0] exa, input bit exl,
                       input bit mw, input logic [4:0] ma, input bit ml, input bit es, input bit cy);
    @(negedge clk);
    rst = r; id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
    ex_wreg = exw; ex_wa = exa; ex_load = exl;
    mem_wreg = mw; mem_wa = ma; mem_load = ml;
    ext_stall = es; cmp_y = cy;
    #2;
    model_check();
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [4:0] rts [6];
    ops = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd0, 6'd8, 6'd35};
    rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2, 5'd3};

    // reset with a branch presented: everything quiet
    apply(1'b1, 1'b1, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("rst_pc_src", pc_src, 1'b0);
    apply(1'b0, 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // BEQ no hazard, taken
    apply(1'b0, 1'b1, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("beq_taken_pc", pc_src, 1'b1);
    check("beq_taken_stall", stall_id, 1'b0);

    // BNE behind an EX load on rs: stall, then resolves once writers are gone
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("bne_load_stall0", stall_id, 1'b1);
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    check("bne_load_pc_during", pc_src, 1'b0);
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("bne_resolved_pc", pc_src, 1'b1);

    // BGTZ with MEM ALU writer: forward rs, but rt is unused
    apply(1'b0, 1'b1, 6'd7, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    check("bgtz_fwd_a", fwd_a, 1'b1);
    apply(1'b0, 1'b1, 6'd7, 5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    check("bgtz_no_fwd_b", fwd_b, 1'b0);

    // BGEZAL on $0 with an EX load to $0: no stall, link written
    apply(1'b0, 1'b1, 6'd1, 5'd0, 5'd17, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("bgezal_link", link_we, 1'b1);
    check("bgezal_nostall", stall_id, 1'b0);

    // taken BEQ frozen three cycles with cmp_y toggling
    apply(1'b0, 1'b1, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("hold_pc1", pc_src, 1'b1);
    apply(1'b0, 1'b1, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("hold_release_pc", pc_src, 1'b1);
    apply(1'b0, 1'b0, 6'd4, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("after_hold_idle", pc_src, 1'b0);

    // reset pulsed mid-stall: stall drops at once, then branch evaluates from idle
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 6'd5, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_stall", stall_id, 1'b0);
    apply(1'b0, 1'b1, 6'd5, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("post_rst_pc", pc_src, 1'b1);

    // id_valid drop aborts a stall
    apply(1'b0, 1'b1, 6'd4, 5'd2, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 6'd4, 5'd2, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 6'd4, 5'd2, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("abort_stall", stall_id, 1'b0);

    // random traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      logic [4:0] rt;
      op = ops[$urandom_range(0, 7)];
      rt = (op == 6'd1) ? rts[$urandom_range(0, 5)] : 5'($urandom_range(0, 7));
      apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), op,
            5'($urandom_range(0, 7)), rt,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
